// File: rtl/apb_pkg.sv
// Shared types and widths for the APB command master.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  typedef struct packed {
    logic                  wr;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB3 master: turns a valid/ready command stream into single APB transfers,
// returning one response pulse per transfer; a watchdog bounds the ACCESS phase.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              p_sel,
  output logic              p_en,
  output logic              p_wr,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] pw_data,
  input  logic              p_ready,
  input  logic [DATA_W-1:0] pr_data,
  input  logic              pslverr
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_t       state;
  apb_req_t         req_q;
  logic [CNT_W-1:0] cnt;

  // Write data is latched as zero for reads, so pw_data needs no muxing.
  assign p_wr    = req_q.wr;
  assign p_addr  = ADDR_W'(req_q.addr);
  assign pw_data = DATA_W'(req_q.wdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= '0;
      cnt         <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      p_sel       <= 1'b0;
      p_en        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q.wr    <= req_wr;
            req_q.addr  <= APB_ADDR_W'(req_addr);
            req_q.wdata <= req_wr ? APB_DATA_W'(req_wdata) : '0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            p_sel       <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          p_en  <= 1'b1;
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          // p_ready takes priority over a watchdog expiry in the same cycle.
          if (p_ready) begin
            rsp_rdata   <= req_q.wr ? '0 : pr_data;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            p_sel       <= 1'b0;
            p_en        <= 1'b0;
            state       <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            p_sel       <= 1'b0;
            p_en        <= 1'b0;
            state       <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
